mem_dados_param: RTL and testbench

Parametrised single-port data memory for the multicycle datapath. It is the successor to the fixed 16x8 data memory.
- Generalised in width, depth and read latency.
- Adds a reset-driven initialisation sequencer that clears the array and loads two seed words (Fibonacci t1/t2).
- Adds a ready/valid read handshake and an error flag for illegal requests.
- Sits between the datapath's ALU address output and the register-file writeback mux.

---
 rtl/mem_dados_pkg.sv | 18 +
 rtl/mem_dados_array.sv | 26 ++
 rtl/mem_dados_param.sv | 153 +++++++++++++++
 tb/tb_mem_dados_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dados_pkg.sv
// Shared types and defaults for the parametrised data memory.
package mem_dados_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Minimum counter width able to index value entries; never below 1 bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/mem_dados_array.sv
// Single-port storage array with synchronous write and synchronous read.
module mem_dados_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: storage has no reset so it maps onto plain RAM; the owner clears it by sweeping.
    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_dados_param.sv
// Data memory with reset-time init sweep, ready/valid reads and an illegal-request flag.
module mem_dados_param
    import mem_dados_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DEPTH   = DEF_DEPTH,
    parameter int                OUT_REG = 0,
    parameter logic [DATA_W-1:0] INIT0   = DATA_W'(1),
    parameter logic [DATA_W-1:0] INIT1   = DATA_W'(1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] endereco,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] dado_in,
    output logic [DATA_W-1:0] dado_out,
    output logic              dado_valid,
    output logic              ready,
    output logic              erro
);

    localparam int              AW      = clog2(DEPTH);
    localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    state_t          r_state;
    logic [AW-1:0]   r_init_cnt;
    logic            r_ready;
    logic            r_rd_s1;
    logic            r_oor_s1;
    logic            r_err_s1;
    logic            r_erro;

    logic              w_in_range;
    logic              w_rd_req;
    logic              w_wr_req;
    logic              w_err_req;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [AW-1:0]     w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [DATA_W-1:0] w_init_word;
    logic [DATA_W-1:0] w_rd_word;

    // Requests only count once ready is visible; an out-of-range read still returns a (zero) word.
    assign w_in_range = {1'b0, endereco} < DEPTH_X;
    assign w_rd_req   = r_ready & MemRead & ~MemWrite;
    assign w_wr_req   = r_ready & MemWrite & ~MemRead & w_in_range;
    assign w_err_req  = r_ready & (MemRead | MemWrite) & ((MemRead & MemWrite) | ~w_in_range);

    assign w_init_word = (r_init_cnt == '0)     ? INIT0 :
                         (r_init_cnt == AW'(1)) ? INIT1 : '0;

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        w_mem_we    = w_wr_req;
        w_mem_re    = w_rd_req & w_in_range;
        w_mem_addr  = endereco[AW-1:0];
        w_mem_wdata = dado_in;
        if (r_state == ST_INIT) begin
            w_mem_we    = 1'b1;
            w_mem_re    = 1'b0;
            w_mem_addr  = r_init_cnt;
            w_mem_wdata = w_init_word;
        end
    end

    mem_dados_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clock   (clock),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_ready <= 1'b0;
                    if (r_init_cnt == LAST) r_state <= ST_RUN;
                    else                    r_init_cnt <= r_init_cnt + 1'b1;
                end
                ST_RUN:  r_ready <= 1'b1;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_s1  <= 1'b0;
            r_oor_s1 <= 1'b0;
            r_err_s1 <= 1'b0;
            r_erro   <= 1'b0;
        end else begin
            r_rd_s1  <= w_rd_req;
            r_oor_s1 <= ~w_in_range;
            r_err_s1 <= w_err_req;
            r_erro   <= r_err_s1;
        end
    end

    assign w_rd_word = r_oor_s1 ? '0 : w_mem_rdata;

    generate
        if (OUT_REG == 0) begin : g_lat1
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    dado_out   <= '0;
                    dado_valid <= 1'b0;
                end else begin
                    dado_valid <= r_rd_s1;
                    if (r_rd_s1) dado_out <= w_rd_word;
                end
            end
        end else begin : g_lat2
            logic              r_rd_s2;
            logic [DATA_W-1:0] r_data_s2;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_rd_s2    <= 1'b0;
                    r_data_s2  <= '0;
                    dado_out   <= '0;
                    dado_valid <= 1'b0;
                end else begin
                    r_rd_s2    <= r_rd_s1;
                    dado_valid <= r_rd_s2;
                    if (r_rd_s1) r_data_s2 <= w_rd_word;
                    if (r_rd_s2) dado_out  <= r_data_s2;
                end
            end
        end
    endgenerate

    assign ready = r_ready;
    assign erro  = r_erro;

endmodule

// File: tb/tb_mem_dados_param.sv
// Scoreboard bench: latency-1 and latency-2 instances share stimulus and are checked every cycle.
module tb_mem_dados_param;

    typedef struct {
        logic [7:0] data;
        int         due;
    } sb_t;

    logic       clock;
    logic       reset_n;
    logic [7:0] endereco;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] dado_in;

    logic [7:0] dado_out0, dado_out1;
    logic       dado_valid0, dado_valid1;
    logic       ready0, ready1;
    logic       erro0, erro1;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    sb_t        q0[$];
    sb_t        q1[$];
    int         eq0[$];
    int         eq1[$];
    logic [7:0] last0 = '0;
    logic [7:0] last1 = '0;
    logic [7:0] model [16];

    mem_dados_param #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(16), .OUT_REG(0), .INIT0(8'd1), .INIT1(8'd1)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .endereco(endereco), .MemRead(MemRead),
        .MemWrite(MemWrite), .dado_in(dado_in), .dado_out(dado_out0),
        .dado_valid(dado_valid0), .ready(ready0), .erro(erro0)
    );

    mem_dados_param #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(16), .OUT_REG(1), .INIT0(8'd1), .INIT1(8'd1)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .endereco(endereco), .MemRead(MemRead),
        .MemWrite(MemWrite), .dado_in(dado_in), .dado_out(dado_out1),
        .dado_valid(dado_valid1), .ready(ready1), .erro(erro1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Latency-1 instance monitor
    initial forever begin
        logic ev, ee;
        @(negedge clock);
        ev = (q0.size() > 0) && (q0[0].due == cyc);
        check("valid0", 32'(dado_valid0), 32'(ev));
        if (ev) begin
            last0 = q0[0].data;
            void'(q0.pop_front());
        end
        check("data0", 32'(dado_out0), 32'(last0));
        ee = (eq0.size() > 0) && (eq0[0] == cyc);
        check("erro0", 32'(erro0), 32'(ee));
        if (ee) void'(eq0.pop_front());
    end

    // Latency-2 instance monitor
    initial forever begin
        logic ev, ee;
        @(negedge clock);
        ev = (q1.size() > 0) && (q1[0].due == cyc);
        check("valid1", 32'(dado_valid1), 32'(ev));
        if (ev) begin
            last1 = q1[0].data;
            void'(q1.pop_front());
        end
        check("data1", 32'(dado_out1), 32'(last1));
        ee = (eq1.size() > 0) && (eq1[0] == cyc);
        check("erro1", 32'(erro1), 32'(ee));
        if (ee) void'(eq1.pop_front());
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic model_init();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        model[0] = 8'd1;
        model[1] = 8'd1;
    endtask

    task automatic clear_inputs();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        endereco = 8'h00;
        dado_in  = 8'h00;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives one request for the next edge and records what each instance must produce.
    task automatic req(input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [7:0] data, input logic [7:0] exp);
        logic inr;
        int   n;
        inr = (addr < 8'd16);
        n   = cyc + 1;
        MemRead  = rd;
        MemWrite = wr;
        endereco = addr;
        dado_in  = data;
        if (rd && !wr) begin
            q0.push_back(sb_t'{inr ? exp : 8'h00, n + 1});
            q1.push_back(sb_t'{inr ? exp : 8'h00, n + 2});
        end
        if ((rd || wr) && (!inr || (rd && wr))) begin
            eq0.push_back(n + 1);
            eq1.push_back(n + 1);
        end
        if (wr && !rd && inr) model[addr[3:0]] = data;
        @(posedge clock);
        #1;
    endtask

    task automatic hit_reset();
        reset_n = 1'b0;
        clear_inputs();
        q0.delete();
        q1.delete();
        eq0.delete();
        eq1.delete();
        last0 = '0;
        last1 = '0;
        model_init();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Counts edges after reset release until ready; optionally holds a write that must be ignored.
    task automatic wait_ready(input logic poke, input string tag);
        int n;
        n = 0;
        if (poke) begin
            MemWrite = 1'b1;
            endereco = 8'h00;
            dado_in  = 8'h99;
        end
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!ready0 && n < 40);
        clear_inputs();
        check(tag, 32'(n), 32'd17);
        check({tag, "_r1"}, 32'(ready1), 32'd1);
    endtask

    initial begin
        logic [7:0] a, b, s;
        reset_n = 1'b0;
        clear_inputs();
        model_init();
        repeat (2) @(posedge clock);
        #1;
        check("rst_out0",   32'(dado_out0),   32'h0);
        check("rst_valid0", 32'(dado_valid0), 32'h0);
        check("rst_ready0", 32'(ready0),      32'h0);
        check("rst_ready1", 32'(ready1),      32'h0);
        check("rst_erro1",  32'(erro1),       32'h0);

        reset_n = 1'b1;
        wait_ready(1'b1, "ready_after_reset");

        req(1, 0, 8'd0,  8'h00, 8'd1);
        req(1, 0, 8'd1,  8'h00, 8'd1);
        req(1, 0, 8'd2,  8'h00, 8'd0);
        req(1, 0, 8'd15, 8'h00, 8'd0);
        idle(3);

        req(0, 1, 8'd5, 8'hA5, 8'h00);
        req(1, 0, 8'd5, 8'h00, 8'hA5);
        idle(3);

        req(1, 0, 8'd20, 8'h00, 8'h00);
        req(0, 1, 8'd16, 8'h3C, 8'h00);
        for (int i = 0; i < 16; i++) req(1, 0, 8'(i), 8'h00, model[i]);
        idle(3);

        req(1, 1, 8'd3, 8'hFF, 8'h00);
        idle(1);
        req(1, 0, 8'd3, 8'h00, 8'h00);
        idle(3);

        req(0, 1, 8'd4, 8'h77, 8'h00);
        req(1, 0, 8'd4, 8'h00, 8'h77);
        idle(3);
        req(1, 0, 8'd4, 8'h00, 8'h77);
        hit_reset();
        repeat (8) begin
            @(posedge clock);
            #1;
        end
        check("mid_init_ready0", 32'(ready0), 32'h0);
        hit_reset();
        wait_ready(1'b0, "ready_after_pulse");
        req(1, 0, 8'd4, 8'h00, 8'h00);
        req(1, 0, 8'd0, 8'h00, 8'd1);
        idle(3);

        a = 8'd1;
        b = 8'd1;
        for (int k = 0; k < 6; k++) begin
            req(1, 0, 8'd0, 8'h00, a);
            req(1, 0, 8'd1, 8'h00, b);
            s = a + b;
            req(0, 1, 8'd2, s, 8'h00);
            req(1, 0, 8'd2, 8'h00, s);
            req(0, 1, 8'd0, b, 8'h00);
            req(0, 1, 8'd1, s, 8'h00);
            a = b;
            b = s;
        end
        idle(5);

        check("scoreboard_drained", 32'(q0.size() + q1.size() + eq0.size() + eq1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
